alu_sequencer: RTL and testbench

//  Sequences the ALU output stage: accepts an ALU op request and wins the main
//  bus from the bus arbiter. Drives op select and carry-select (AC6_CS0/AC7_CS1),

---
 rtl/alu_sequencer_if.sv | 34 +++
 rtl/alu_sequencer.sv | 160 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Request, bus-arbitration and ALU-drive signals of the ALU output sequencer.
// Request handshake: a request transfers on the rising edge where ReqValid and ReqReady are both 1; ReqOp/ReqWide/ReqCarry/ReqKeepFlags must be stable while ReqValid is 1.
interface alu_sequencer_if #(
    parameter int OP_WIDTH = 4
);
    logic                ReqValid;
    logic                ReqReady;
    logic [OP_WIDTH-1:0] ReqOp;
    logic                ReqWide;
    logic [1:0]          ReqCarry;
    logic                ReqKeepFlags;
    logic                BusGrant;
    logic                BusRequest;
    logic [OP_WIDTH-1:0] AluOp;
    logic                AC6_CS0;
    logic                AC7_CS1;
    logic                ByteSel;
    logic                Alu_Assert;
    logic                FlagsLoad;
    logic                Done;
    logic                ErrTimeout;

    modport master (
        input  ReqValid, ReqOp, ReqWide, ReqCarry, ReqKeepFlags, BusGrant,
        output ReqReady, BusRequest, AluOp, AC6_CS0, AC7_CS1, ByteSel,
               Alu_Assert, FlagsLoad, Done, ErrTimeout
    );

    modport slave (
        output ReqValid, ReqOp, ReqWide, ReqCarry, ReqKeepFlags, BusGrant,
        input  ReqReady, BusRequest, AluOp, AC6_CS0, AC7_CS1, ByteSel,
               Alu_Assert, FlagsLoad, Done, ErrTimeout
    );
endinterface

// File: rtl/alu_sequencer.sv
// ALU output-stage sequencer: wins the main bus, settles op/carry select, then
// pulses Alu_Assert/FlagsLoad once per byte pass (two passes for 16-bit ops).
module alu_sequencer #(
    parameter int SETTLE_CYCLES  = 1,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int OP_WIDTH       = 4
) (
    input  logic                   AluClock,
    input  logic                   Reset,
    alu_sequencer_if.master        bus,
    output logic [2:0]             dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_SETUP  = 3'd2,
        S_ASSERT = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [2:0] SETTLE_INIT = 3'(SETTLE_CYCLES);
    localparam logic [7:0] TOUT_LAST   = 8'(TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    logic [OP_WIDTH-1:0]   op_q;
    logic                  wide_q;
    logic [1:0]            cs_q;
    logic                  keep_q;
    logic                  bytesel_q;
    logic                  err_q;
    logic [2:0]            settle_q;
    logic [7:0]            tout_q;

    logic accept;
    logic settle_load;
    logic settle_dec;
    logic tout_clr;
    logic tout_inc;
    logic high_pass;
    logic timeout_hit;

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        settle_load = 1'b0;
        settle_dec  = 1'b0;
        tout_clr    = 1'b0;
        tout_inc    = 1'b0;
        high_pass   = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.ReqValid) begin
                    accept  = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.BusGrant) begin
                    if (SETTLE_CYCLES == 0) begin
                        state_d = S_ASSERT;
                    end else begin
                        state_d     = S_SETUP;
                        settle_load = 1'b1;
                    end
                end else if (tout_q == TOUT_LAST) begin
                    state_d     = S_DONE;
                    timeout_hit = 1'b1;
                end else begin
                    tout_inc = 1'b1;
                end
            end
            S_SETUP: begin
                // settle_q counts remaining SETUP cycles including this one
                if (settle_q <= 3'd1) begin
                    if (bus.BusGrant) begin
                        state_d = S_ASSERT;
                    end else begin
                        state_d  = S_REQ;
                        tout_clr = 1'b1;
                    end
                end else begin
                    settle_dec = 1'b1;
                end
            end
            S_ASSERT: begin
                if (wide_q && !bytesel_q) begin
                    high_pass   = 1'b1;
                    settle_load = 1'b1;
                    state_d     = S_SETUP;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge AluClock) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            wide_q    <= 1'b0;
            cs_q      <= 2'b00;
            keep_q    <= 1'b0;
            bytesel_q <= 1'b0;
            err_q     <= 1'b0;
            settle_q  <= 3'd0;
            tout_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q      <= bus.ReqOp;
                wide_q    <= bus.ReqWide;
                cs_q      <= bus.ReqCarry;
                keep_q    <= bus.ReqKeepFlags;
                bytesel_q <= 1'b0;
                err_q     <= 1'b0;
                tout_q    <= 8'd0;
            end
            if (settle_load) begin
                settle_q <= SETTLE_INIT;
            end else if (settle_dec) begin
                settle_q <= settle_q - 3'd1;
            end
            if (tout_clr) begin
                tout_q <= 8'd0;
            end else if (tout_inc) begin
                tout_q <= tout_q + 8'd1;
            end
            // high pass chains the low-pass ALU carry (ACarryPrev)
            if (high_pass) begin
                bytesel_q <= 1'b1;
                cs_q      <= 2'b01;
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.ReqReady   = (state_q == S_IDLE);
    assign bus.BusRequest = (state_q == S_REQ) || (state_q == S_SETUP) || (state_q == S_ASSERT);
    assign bus.AluOp      = op_q;
    assign bus.AC6_CS0    = cs_q[0];
    assign bus.AC7_CS1    = cs_q[1];
    assign bus.ByteSel    = bytesel_q;
    assign bus.Alu_Assert = ~(state_q == S_ASSERT);
    assign bus.FlagsLoad  = (state_q == S_ASSERT) && !keep_q;
    assign bus.Done       = (state_q == S_DONE);
    assign bus.ErrTimeout = (state_q == S_DONE) && err_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: latency vectors, directed corner sequences and
// random requests against a transaction-level pass model.
module tb_alu_sequencer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_sequencer_if #(.OP_WIDTH(4)) sif ();
    alu_sequencer_if #(.OP_WIDTH(4)) tif ();
    logic [2:0] dbg_main;
    logic [2:0] dbg_to;

    alu_sequencer #(.SETTLE_CYCLES(1), .TIMEOUT_CYCLES(255), .OP_WIDTH(4)) u_dut (
        .AluClock (clk),
        .Reset    (rst),
        .bus      (sif),
        .dbg_state(dbg_main)
    );

    alu_sequencer #(.SETTLE_CYCLES(1), .TIMEOUT_CYCLES(4), .OP_WIDTH(4)) u_to (
        .AluClock (clk),
        .Reset    (rst),
        .bus      (tif),
        .dbg_state(dbg_to)
    );

    int n_checks = 0;
    int n_errors = 0;

    // {ReqReady, BusRequest, Alu_Assert, FlagsLoad, Done, ErrTimeout, AluOp, CS1, CS0, ByteSel}
    localparam logic [12:0] RESET_OUTS = {1'b1, 1'b0, 1'b1, 10'b0};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [12:0] outs_main();
        return {sif.ReqReady, sif.BusRequest, sif.Alu_Assert, sif.FlagsLoad, sif.Done,
                sif.ErrTimeout, sif.AluOp, sif.AC7_CS1, sif.AC6_CS0, sif.ByteSel};
    endfunction

    // ---------------- invariant monitor ----------------
    logic g_edge = 1'b0;
    logic prev_as = 1'b1;
    always @(posedge clk) g_edge <= sif.BusGrant;
    always @(negedge clk) begin
        if (!rst && sif.Alu_Assert == 1'b0) begin
            check("assert_needs_grant", 32'(g_edge), 32'd1);
            check("assert_single_cycle", 32'(prev_as), 32'd1);
        end
        if (sif.FlagsLoad) check("flags_outside_assert", 32'(sif.Alu_Assert), 32'd0);
        prev_as <= sif.Alu_Assert;
    end

    // ---------------- reference model / scoreboard ----------------
    // event = {op, cs[1:0], byte_sel, flags_load}
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         got_cyc[$];
    logic       bs_hist[$];
    int         done_cyc;
    logic       done_err;
    logic       breq_bad;
    logic       ready_bad;

    function automatic void model_txn(input logic [3:0] op, input logic wide,
                                      input logic [1:0] carry, input logic keep);
        exp_q.push_back({op, carry, 1'b0, ~keep});
        if (wide) exp_q.push_back({op, 2'b01, 1'b1, ~keep});
    endfunction

    task automatic compare_events(input string name);
        check({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0)
            check({name, "_event"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        exp_q.delete();
        got_q.delete();
    endtask

    // ---------------- driver ----------------
    // Sample index 1 is the cycle after the accepting edge. Grant for the next
    // edge is either random or 0 inside the window [lo, hi).
    task automatic run_txn(input logic [3:0] op, input logic wide, input logic [1:0] carry,
                           input logic keep, input bit rnd_grant, input int lo, input int hi,
                           input bit hold_valid);
        int cyc;
        int wait_n;
        got_q.delete();
        got_cyc.delete();
        bs_hist.delete();
        done_cyc  = -1;
        done_err  = 1'b0;
        breq_bad  = 1'b0;
        ready_bad = 1'b0;
        sif.ReqOp        = op;
        sif.ReqWide      = wide;
        sif.ReqCarry     = carry;
        sif.ReqKeepFlags = keep;
        sif.ReqValid     = 1'b1;
        wait_n = 0;
        while (sif.ReqReady !== 1'b1 && wait_n < 50) begin
            step();
            wait_n++;
        end
        step();
        if (!hold_valid) sif.ReqValid = 1'b0;
        cyc = 1;
        while (done_cyc < 0 && cyc < 600) begin
            bs_hist.push_back(sif.ByteSel);
            if (sif.Alu_Assert == 1'b0) begin
                got_q.push_back({sif.AluOp, sif.AC7_CS1, sif.AC6_CS0, sif.ByteSel, sif.FlagsLoad});
                got_cyc.push_back(cyc);
            end
            if (sif.ReqReady) ready_bad = 1'b1;
            if (sif.Done) begin
                done_cyc = cyc;
                done_err = sif.ErrTimeout;
                sif.ReqValid = 1'b0;
            end else if (!sif.BusRequest) begin
                breq_bad = 1'b1;
            end
            if (rnd_grant) sif.BusGrant = ($urandom_range(0, 3) != 0);
            else           sif.BusGrant = !(cyc >= lo && cyc < hi);
            step();
            cyc++;
        end
        sif.ReqValid = 1'b0;
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [3:0] op;
        logic       wide;
        logic [1:0] carry;
        logic       keep;
        int         done_at;
        int         first_at;
        int         second_at;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int nd;
        logic saw_as;
        logic saw_fl;

        vecs[0] = '{4'h1, 1'b0, 2'b00, 1'b0, 4, 3, -1};
        vecs[1] = '{4'h2, 1'b1, 2'b00, 1'b0, 6, 3, 5};
        vecs[2] = '{4'h7, 1'b0, 2'b11, 1'b1, 4, 3, -1};
        vecs[3] = '{4'hA, 1'b1, 2'b10, 1'b1, 6, 3, 5};
        vecs[4] = '{4'hF, 1'b0, 2'b01, 1'b0, 4, 3, -1};

        rst = 1'b1;
        sif.ReqValid = 1'b0; sif.ReqOp = 4'h0; sif.ReqWide = 1'b0;
        sif.ReqCarry = 2'b00; sif.ReqKeepFlags = 1'b0; sif.BusGrant = 1'b0;
        tif.ReqValid = 1'b0; tif.ReqOp = 4'h0; tif.ReqWide = 1'b0;
        tif.ReqCarry = 2'b00; tif.ReqKeepFlags = 1'b0; tif.BusGrant = 1'b0;
        repeat (3) step();
        check("reset_outs", 32'(outs_main()), 32'(RESET_OUTS));
        rst = 1'b0;
        step();
        check("idle_outs", 32'(outs_main()), 32'(RESET_OUTS));

        // latency vectors, grant tied high
        sif.BusGrant = 1'b1;
        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i].op, vecs[i].wide, vecs[i].carry, vecs[i].keep, 1'b0, 0, 0, 1'b0);
            check($sformatf("vec%0d_done_at", i), 32'(done_cyc), 32'(vecs[i].done_at));
            check($sformatf("vec%0d_first_at", i), 32'(got_cyc.size() > 0 ? got_cyc[0] : -1),
                  32'(vecs[i].first_at));
            check($sformatf("vec%0d_second_at", i), 32'(got_cyc.size() > 1 ? got_cyc[1] : -1),
                  32'(vecs[i].second_at));
            check($sformatf("vec%0d_err", i), 32'(done_err), 32'd0);
            check($sformatf("vec%0d_busreq", i), 32'(breq_bad), 32'd0);
            check($sformatf("vec%0d_done_pulse", i), 32'(sif.Done), 32'd0);
            model_txn(vecs[i].op, vecs[i].wide, vecs[i].carry, vecs[i].keep);
            compare_events($sformatf("vec%0d", i));
        end

        // grant withheld for ten REQ cycles
        sif.BusGrant = 1'b0;
        run_txn(4'h3, 1'b0, 2'b10, 1'b0, 1'b0, 0, 10, 1'b0);
        check("withhold_first_at", 32'(got_cyc.size() > 0 ? got_cyc[0] : -1), 32'd12);
        check("withhold_done_at", 32'(done_cyc), 32'd13);
        check("withhold_busreq", 32'(breq_bad), 32'd0);
        check("withhold_err", 32'(done_err), 32'd0);
        model_txn(4'h3, 1'b0, 2'b10, 1'b0);
        compare_events("withhold");

        // grant dropped during the high-pass SETUP
        sif.BusGrant = 1'b1;
        run_txn(4'h5, 1'b1, 2'b11, 1'b0, 1'b0, 4, 7, 1'b0);
        check("regrant_bytesel_in_req", 32'(bs_hist.size() > 5 ? bs_hist[4] : 1'bx), 32'd1);
        check("regrant_second_at", 32'(got_cyc.size() > 1 ? got_cyc[1] : -1), 32'd9);
        check("regrant_done_at", 32'(done_cyc), 32'd10);
        model_txn(4'h5, 1'b1, 2'b11, 1'b0);
        compare_events("regrant");

        // ReqValid held during busy is neither accepted nor queued
        sif.BusGrant = 1'b1;
        run_txn(4'h9, 1'b0, 2'b00, 1'b0, 1'b0, 0, 0, 1'b1);
        check("busy_ready_low", 32'(ready_bad), 32'd0);
        check("busy_done_at", 32'(done_cyc), 32'd4);
        step();
        check("busy_not_queued", 32'({sif.ReqReady, sif.BusRequest}), 32'(2'b10));
        model_txn(4'h9, 1'b0, 2'b00, 1'b0);
        compare_events("busy");

        // timeout instance: grant never given
        tif.ReqOp = 4'h6; tif.ReqWide = 1'b1; tif.ReqCarry = 2'b01; tif.ReqKeepFlags = 1'b0;
        tif.ReqValid = 1'b1;
        step();
        tif.ReqValid = 1'b0;
        cyc = 1; nd = -1; saw_as = 1'b0; saw_fl = 1'b0;
        while (nd < 0 && cyc < 30) begin
            if (tif.Alu_Assert == 1'b0) saw_as = 1'b1;
            if (tif.FlagsLoad) saw_fl = 1'b1;
            if (tif.Done) begin
                nd = cyc;
                check("tout_err_flag", 32'(tif.ErrTimeout), 32'd1);
            end
            step();
            cyc++;
        end
        check("tout_done_at", 32'(nd), 32'd5);
        check("tout_no_assert", 32'(saw_as), 32'd0);
        check("tout_no_flags", 32'(saw_fl), 32'd0);
        check("tout_back_idle", 32'({tif.ReqReady, tif.Done, tif.ErrTimeout, tif.BusRequest}),
              32'(4'b1000));

        // reset in SETUP and in ASSERT
        for (int k = 2; k <= 3; k++) begin
            sif.BusGrant = 1'b1;
            sif.ReqOp = 4'hC; sif.ReqWide = 1'b1; sif.ReqCarry = 2'b11; sif.ReqKeepFlags = 1'b0;
            sif.ReqValid = 1'b1;
            step();
            sif.ReqValid = 1'b0;
            for (int j = 1; j < k; j++) step();
            if (k == 3) check("pre_reset_in_assert", 32'(sif.Alu_Assert), 32'd0);
            rst = 1'b1;
            step();
            rst = 1'b0;
            check($sformatf("reset_at_%0d_outs", k), 32'(outs_main()), 32'(RESET_OUTS));
            nd = 0;
            for (int j = 0; j < 8; j++) begin
                if (sif.Done || !sif.Alu_Assert) nd++;
                step();
            end
            check($sformatf("reset_at_%0d_dropped", k), 32'(nd), 32'd0);
        end

        // random requests with random grant against the pass model
        for (int i = 0; i < 40; i++) begin
            logic [3:0] op;
            logic       wide;
            logic [1:0] carry;
            logic       keep;
            op    = 4'($urandom_range(0, 15));
            wide  = 1'($urandom_range(0, 1));
            carry = 2'($urandom_range(0, 3));
            keep  = 1'($urandom_range(0, 1));
            sif.BusGrant = 1'($urandom_range(0, 1));
            run_txn(op, wide, carry, keep, 1'b1, 0, 0, 1'b0);
            check($sformatf("rnd%0d_done", i), 32'(done_cyc > 0), 32'd1);
            check($sformatf("rnd%0d_err", i), 32'(done_err), 32'd0);
            model_txn(op, wide, carry, keep);
            compare_events($sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
